// File: rtl/pio_host_bridge.sv
// pio_host_bridge
// Byte-stream command bridge placed directly upstream of the PIO block.
// Assembles fixed-length command frames from a byte receiver, issues one-cycle
// action strobes on the PIO configuration bus, and for PULL actions streams
// the captured PIO dout word back as little-endian bytes.
// Optional feature macro: PIO_HOST_BRIDGE_CHECKSUM_EN
//   defined   -> 7-byte frames (b6 = XOR of b0..b5), 5-byte readback (4 data
//                bytes + XOR of them); a bad check byte discards the frame.
//   undefined -> 6-byte frames, 4-byte readback; frame_err only on timeout.
module pio_host_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [3:0]  PULL_CODE      = 4'd3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [3:0]  action,
   output logic [1:0]  mindex,
   output logic [4:0]  index,
   output logic [31:0] din,
   input  logic [31:0] dout,
   output logic        busy,
   output logic        frame_err
);

`ifdef PIO_HOST_BRIDGE_CHECKSUM_EN
   localparam int FRAME_LEN = 7;
   localparam int TX_BYTES  = 5;
`else
   localparam int FRAME_LEN = 6;
   localparam int TX_BYTES  = 4;
`endif
   // The last frame byte is consumed straight from rx_data, so only the
   // earlier bytes need shadow storage.
   localparam int SHADOW_N = FRAME_LEN - 1;
   localparam int TX_W     = TX_BYTES * 8;
   localparam int IDLE_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);
   localparam logic [2:0] LAST_TX   = 3'(TX_BYTES - 1);

   typedef enum logic [1:0] {
      ST_RX,
      ST_ISSUE,
      ST_CAPTURE,
      ST_TX
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [2:0]          byte_cnt_reg;
   logic [IDLE_W-1:0]   idle_cnt_reg;
   logic [2:0]          tx_cnt_reg;
   logic [TX_W-1:0]     tx_shift_reg;
   logic [TX_W-1:0]     tx_load;
   logic                rx_ready_reg;
   logic                tx_valid_reg;
   logic                frame_err_reg;
   logic [3:0]          action_reg;
   logic [1:0]          mindex_reg;
   logic [4:0]          index_reg;
   logic [31:0]         din_reg;
   logic [SHADOW_N*8-1:0] shadow_bytes;
   logic [47:0]         frame_bytes;   // b0..b5 of the frame being completed
   logic                rx_fire;
   logic                tx_fire;
   logic                tx_last;
   logic                frame_last;
   logic                frame_ok;
   logic                frame_issue;
   logic                frame_bad;
   logic                idle_tick;
   logic                timeout_hit;
   logic                unused_bits;

   assign rx_fire     = rx_valid && rx_ready_reg;
   assign tx_fire     = tx_valid_reg && tx_ready;
   assign tx_last     = tx_fire && (tx_cnt_reg == LAST_TX);
   assign frame_last  = rx_fire && (byte_cnt_reg == LAST_BYTE);
   assign frame_issue = frame_last && frame_ok;
   assign frame_bad   = frame_last && !frame_ok;
   assign idle_tick   = (state_reg == ST_RX) && (byte_cnt_reg != 3'd0) && !rx_fire;

   // Per-byte shadow registers, each written when its slot number is received
   generate
      for (genvar gi = 0; gi < SHADOW_N; gi++) begin : g_shadow
         logic [7:0] byte_reg;
         // Capture frame byte gi
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               byte_reg <= 8'd0;
            else if (rx_fire && (byte_cnt_reg == 3'(gi)))
               byte_reg <= rx_data;
         end
         assign shadow_bytes[gi*8 +: 8] = byte_reg;
      end
   endgenerate

`ifdef PIO_HOST_BRIDGE_CHECKSUM_EN
   logic [7:0] xor_acc_reg;
   // Running XOR of the frame payload, restarted by the first byte of a frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         xor_acc_reg <= 8'd0;
      else if (rx_fire)
         xor_acc_reg <= (byte_cnt_reg == 3'd0) ? rx_data : (xor_acc_reg ^ rx_data);
   end
   assign frame_ok    = (xor_acc_reg == rx_data);
   assign frame_bytes = shadow_bytes;
   assign tx_load     = {dout[31:24] ^ dout[23:16] ^ dout[15:8] ^ dout[7:0], dout};
`else
   assign frame_ok    = 1'b1;
   assign frame_bytes = {rx_data, shadow_bytes};
   assign tx_load     = dout;
`endif

   // Reserved header bits carry no meaning
   assign unused_bits = &{1'b0, frame_bytes[7:6], frame_bytes[15:13]};

   // Partial-frame timeout fires on the idle cycle that completes the budget
   generate
      if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end else begin : g_timeout
         assign timeout_hit = idle_tick && (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= ST_RX;
      else
         state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RX:      if (frame_issue) state_next = ST_ISSUE;
         ST_ISSUE:   state_next = (action_reg == PULL_CODE) ? ST_CAPTURE : ST_RX;
         ST_CAPTURE: state_next = ST_TX;
         ST_TX:      if (tx_last) state_next = ST_RX;
         default:    state_next = ST_RX;
      endcase
   end

   // Frame byte counter: advances per accepted byte, clears on a finished or timed-out frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         byte_cnt_reg <= 3'd0;
      else if (frame_last || timeout_hit)
         byte_cnt_reg <= 3'd0;
      else if (rx_fire)
         byte_cnt_reg <= byte_cnt_reg + 3'd1;
   end

   // Idle counter: runs only while a partial frame waits for its next byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         idle_cnt_reg <= '0;
      else if (!idle_tick || timeout_hit)
         idle_cnt_reg <= '0;
      else
         idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
   end

   // PIO bus: action strobes for the ISSUE cycle only; the rest hold until the next issue
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         action_reg <= 4'd0;
         mindex_reg <= 2'd0;
         index_reg  <= 5'd0;
         din_reg    <= 32'd0;
      end else begin
         action_reg <= frame_issue ? frame_bytes[3:0] : 4'd0;
         if (frame_issue) begin
            mindex_reg <= frame_bytes[5:4];
            index_reg  <= frame_bytes[12:8];
            din_reg    <= frame_bytes[47:16];
         end
      end
   end

   // Handshake and error flags, registered from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_ready_reg  <= 1'b0;
         tx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         rx_ready_reg  <= (state_next == ST_RX);
         tx_valid_reg  <= (state_next == ST_TX);
         frame_err_reg <= timeout_hit || frame_bad;
      end
   end

   // Readback shifter: loads dout in CAPTURE, drops one byte per handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_shift_reg <= '0;
         tx_cnt_reg   <= 3'd0;
      end else if (state_reg == ST_CAPTURE) begin
         tx_shift_reg <= tx_load;
         tx_cnt_reg   <= 3'd0;
      end else if (tx_fire) begin
         tx_shift_reg <= tx_shift_reg >> 8;
         tx_cnt_reg   <= tx_cnt_reg + 3'd1;
      end
   end

   assign rx_ready  = rx_ready_reg;
   assign tx_valid  = tx_valid_reg;
   assign tx_data   = tx_shift_reg[7:0];
   assign action    = action_reg;
   assign mindex    = mindex_reg;
   assign index     = index_reg;
   assign din       = din_reg;
   assign busy      = (state_reg != ST_RX);
   assign frame_err = frame_err_reg;

endmodule
